// File: rtl/multi_debounce_if.sv
// Bundles the button pins and every debounced output of the multi-channel
// debouncer. The debouncer connects through the slave modport. The board
// side, or a testbench, drives the pins through the master modport.
interface multi_debounce_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_in;
    logic [CHANNELS-1:0] button_out;
    logic [CHANNELS-1:0] button_posedge;
    logic [CHANNELS-1:0] button_negedge;
    logic [CHANNELS-1:0] long_press;
    logic [CHANNELS-1:0] button_repeat;

    modport slave (
        input  button_in,
        output button_out,
        output button_posedge,
        output button_negedge,
        output long_press,
        output button_repeat
    );

    modport master (
        output button_in,
        input  button_out,
        input  button_posedge,
        input  button_negedge,
        input  long_press,
        input  button_repeat
    );
endinterface

// File: rtl/multi_debounce.sv
// multi_debounce: debounces CHANNELS independent raw button pins.
// Each channel has the following parts:
//   - a 2-FF synchroniser
//   - a stability counter that gates the registered level
//   - registered 1-cycle edge pulses
//   - a long-press detector
// The optional auto-repeat is enabled by defining DEBOUNCE_REPEAT_EN.
// Without that macro, button_repeat is held at 0 and HELD only suppresses
// further long_press pulses.
//
// Per-channel press FSM:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | button_out at IDLE_LEVEL (released); hold counter cleared
//   ST_PRESSED | button_out active, counting towards LONG_CYCLES
//   ST_HELD    | long_press already fired; hcnt times auto-repeat (if enabled)
module multi_debounce #(
    parameter int   CHANNELS     = 4,
    parameter int   CLK_FREQ_KHZ = 50000,
    parameter int   DEBOUNCE_MS  = 20,
    parameter int   LONG_MS      = 1000,
    parameter int   REPEAT_MS    = 200,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    multi_debounce_if.slave bus
);

    localparam int DB_CYCLES   = DEBOUNCE_MS * CLK_FREQ_KHZ;
    localparam int LONG_CYCLES = LONG_MS * CLK_FREQ_KHZ;
    localparam int REP_CYCLES  = REPEAT_MS * CLK_FREQ_KHZ;
    localparam int HOLD_MAX    = (LONG_CYCLES > REP_CYCLES) ? LONG_CYCLES : REP_CYCLES;
    localparam int CW          = $clog2(DB_CYCLES + 1);
    localparam int HW          = $clog2(HOLD_MAX + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYCLES - 1);
`endif

    localparam logic [CHANNELS-1:0] IDLE_VEC = {CHANNELS{IDLE_LEVEL}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] out_dly_q, out_dly_d;
    logic [CHANNELS-1:0] pos_q, pos_d;
    logic [CHANNELS-1:0] neg_q, neg_d;
    logic [CHANNELS-1:0] long_q, long_d;
    logic [CHANNELS-1:0] rep_q, rep_d;
    logic [CHANNELS-1:0] active;

    logic [CW-1:0] cnt_q  [CHANNELS];
    logic [CW-1:0] cnt_d  [CHANNELS];
    logic [HW-1:0] hcnt_q [CHANNELS];
    logic [HW-1:0] hcnt_d [CHANNELS];
    state_t        state_q [CHANNELS];
    state_t        state_d [CHANNELS];

    // A channel is active whenever its debounced level differs from the released level.
    assign active = out_q ^ IDLE_VEC;

    // Synchroniser, debounced level, stability counters and edge-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= IDLE_VEC;
            sync2_q   <= IDLE_VEC;
            out_q     <= IDLE_VEC;
            out_dly_q <= IDLE_VEC;
            pos_q     <= '0;
            neg_q     <= '0;
            long_q    <= '0;
            rep_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            out_q     <= out_d;
            out_dly_q <= out_dly_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // FSM state register together with the hold counter it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                hcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    // Debounce datapath.
    // The level only follows sync after DB_CYCLES consecutive disagreeing samples.
    // Edges compare the level against its one-cycle-delayed copy, so each pulse
    // lands the cycle after the level changes.
    always_comb begin
        sync1_d   = bus.button_in;
        sync2_d   = sync1_q;
        out_d     = out_q;
        out_dly_d = out_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                out_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        neg_d = out_dly_q & ~out_q;
        pos_d = ~out_dly_q & out_q;
    end

    // Next-state logic and hold counter.
    // Release always returns the channel to IDLE and clears the count.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            hcnt_d[i]  = hcnt_q[i];
            if (!active[i]) begin
                state_d[i] = ST_IDLE;
                hcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        state_d[i] = ST_PRESSED;
                        hcnt_d[i]  = hcnt_q[i] + HW'(1);
                    end
                    ST_PRESSED: begin
                        if (long_d[i]) begin
                            state_d[i] = ST_HELD;
                            hcnt_d[i]  = '0;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + HW'(1);
                        end
                    end
                    ST_HELD: begin
`ifdef DEBOUNCE_REPEAT_EN
                        if (rep_d[i]) begin
                            hcnt_d[i] = '0;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + HW'(1);
                        end
`else
                        // Nothing left to time once long_press has fired.
                        hcnt_d[i] = '0;
`endif
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        hcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Output decode: long-press and repeat strobes, registered into long_q and rep_q.
    always_comb begin
        long_d = '0;
        rep_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            long_d[i] = active[i] && (state_q[i] == ST_PRESSED) && (hcnt_q[i] == LONG_LAST);
`ifdef DEBOUNCE_REPEAT_EN
            rep_d[i]  = active[i] && (state_q[i] == ST_HELD) && (hcnt_q[i] == REP_LAST);
`endif
        end
    end

    assign bus.button_out     = out_q;
    assign bus.button_posedge = pos_q;
    assign bus.button_negedge = neg_q;
    assign bus.long_press     = long_q;
    assign bus.button_repeat  = rep_q;

endmodule
